// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle for serial_adder_ctrl.
// SUB exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             START;
   logic [WIDTH-1:0] OP_A;
   logic [WIDTH-1:0] OP_B;
`ifdef SERIAL_ADDER_SUB_EN
   logic             SUB;
`endif
   logic             BUSY;
   logic             DONE;
   logic [WIDTH-1:0] RESULT;
   logic             COUT;

`ifdef SERIAL_ADDER_SUB_EN
   modport master (output START, OP_A, OP_B, SUB, input BUSY, DONE, RESULT, COUT);
   modport slave  (input START, OP_A, OP_B, SUB, output BUSY, DONE, RESULT, COUT);
`else
   modport master (output START, OP_A, OP_B, input BUSY, DONE, RESULT, COUT);
   modport slave  (input START, OP_A, OP_B, output BUSY, DONE, RESULT, COUT);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: two half_adder cells plus a carry flop, one bit per clock, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the SUB (A-B) mode.
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic CLK,
   input  logic RST,
   serial_adder_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             state_q,  state_d;
   logic [WIDTH-1:0]   a_sr_q,   a_sr_d;
   logic [WIDTH-1:0]   b_sr_q,   b_sr_d;
   logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic               carry_q,  carry_d;
   logic               busy_q,   busy_d;
   logic               done_q,   done_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               cout_q,   cout_d;

   logic s0, c0, s_bit, c1, sub_sel;
   logic [WIDTH-1:0] sum_next;

`ifdef SERIAL_ADDER_SUB_EN
   assign sub_sel = bus.SUB;
`else
   assign sub_sel = 1'b0;
`endif

   half_adder u_ha0 (.a(a_sr_q[0]), .b(b_sr_q[0]), .s(s0),    .c(c0));
   half_adder u_ha1 (.a(s0),        .b(carry_q),   .s(s_bit), .c(c1));

   assign sum_next = {s_bit, sum_sr_q[WIDTH-1:1]};

   always_comb begin
      // NOTE: every target gets its hold value first so no path leaves it unassigned (no latches).
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      sum_sr_d = sum_sr_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      result_d = result_q;
      cout_d   = cout_q;
      case (state_q)
         S_IDLE: begin
            if (bus.START) begin
               a_sr_d   = bus.OP_A;
               // Subtract as A + ~B + 1: invert B and seed the carry.
               b_sr_d   = sub_sel ? ~bus.OP_B : bus.OP_B;
               carry_d  = sub_sel;
               sum_sr_d = '0;
               cnt_d    = '0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            sum_sr_d = sum_next;
            carry_d  = c0 | c1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               result_d = sum_next;
               cout_d   = c0 | c1;
               state_d  = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge CLK) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (RST) begin
         state_q  <= S_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         sum_sr_q <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         sum_sr_q <= sum_sr_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         cout_q   <= cout_d;
      end
   end

   assign bus.BUSY   = busy_q;
   assign bus.DONE   = done_q;
   assign bus.RESULT = result_q;
   assign bus.COUT   = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: stimulus pushes hand-computed results, a DONE monitor pops them.
// Define SERIAL_ADDER_SUB_EN to also exercise subtract mode.
module tb_serial_adder_ctrl;
   localparam int W = 8;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   serial_adder_ctrl_if #(.WIDTH(W)) bus ();
   serial_adder_ctrl #(.WIDTH(W)) dut (.CLK(CLK), .RST(RST), .bus(bus));

   typedef struct {
      logic [W-1:0] res;
      logic         cout;
      int           cyc;
   } exp_t;

   exp_t sb_q[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_done   = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   always @(negedge CLK) begin : monitor
      exp_t e;
      if (bus.DONE === 1'b1) begin
         n_done++;
         if (sb_q.size() == 0) check("unexpected_done", 1, 0);
         else begin
            e = sb_q.pop_front();
            check("result",   bus.RESULT, e.res);
            check("cout",     bus.COUT,   e.cout);
            check("done_cyc", cyc,        e.cyc);
         end
      end
   end

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic [W-1:0] er, input logic ec, input bit push, input bit hold,
                        output int k);
      @(negedge CLK);
      bus.START = 1'b1;
      bus.OP_A  = a;
      bus.OP_B  = b;
`ifdef SERIAL_ADDER_SUB_EN
      bus.SUB   = sub;
`else
      if (sub) $display("note: subtract requested in add-only build");
`endif
      @(posedge CLK);
      #1;
      k = cyc;
      if (push) sb_q.push_back(exp_t'{er, ec, k + W});
      if (!hold) bus.START = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 60; i++) begin
         @(negedge CLK);
         if (sb_q.size() == 0 && bus.BUSY == 1'b0) break;
      end
      check(name, 32'(sb_q.size()) + 32'(bus.BUSY), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected finish before 100us");
      $fatal(1);
   end

   initial begin
      int k;
      int n;
      RST       = 1'b1;
      bus.START = 1'b0;
      bus.OP_A  = '0;
      bus.OP_B  = '0;
`ifdef SERIAL_ADDER_SUB_EN
      bus.SUB   = 1'b0;
`endif
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst_busy",   bus.BUSY,   0);
      check("rst_done",   bus.DONE,   0);
      check("rst_result", bus.RESULT, 0);
      check("rst_cout",   bus.COUT,   0);
      RST = 1'b0;

      // Zero operands; BUSY spans RUN (8 cycles) plus DONE.
      do_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1, 0, k);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (!bus.BUSY) break;
         n++;
      end
      check("t1_busy_len", n, 9);
      wait_idle("t1_idle");

      do_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1, 0, k);
      wait_idle("t2_idle");
      repeat (3) @(negedge CLK);
      check("t2_hold_result", bus.RESULT, 8'h96);
      check("t2_hold_cout",   bus.COUT,   0);

      do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1, 0, k);
      wait_idle("t3_idle");

      // START held high; new operands mid-RUN must not disturb the running op.
      do_op(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1, 1, k);
      repeat (3) @(negedge CLK);
      bus.OP_A = 8'h11;
      bus.OP_B = 8'h01;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (!bus.BUSY) break;
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (bus.BUSY) break;
      end
      check("t4_reaccept_cyc", cyc, k + 10);
      sb_q.push_back(exp_t'{8'h12, 1'b0, cyc + W});
      bus.START = 1'b0;
      wait_idle("t4_idle");

      // Abort after three processed bits.
      n = n_done;
      do_op(8'hAA, 8'h55, 1'b0, 8'h00, 1'b0, 0, 0, k);
      repeat (4) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      check("t5_busy",   bus.BUSY,   0);
      check("t5_done",   bus.DONE,   0);
      check("t5_result", bus.RESULT, 0);
      check("t5_cout",   bus.COUT,   0);
      RST = 1'b0;
      repeat (15) @(negedge CLK);
      check("t5_no_done", n_done - n, 0);
      do_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1, 0, k);
      wait_idle("t5_idle");

`ifdef SERIAL_ADDER_SUB_EN
      do_op(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1, 0, k);
      wait_idle("t6a_idle");
      do_op(8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 1, 0, k);
      wait_idle("t6b_idle");
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
